// File: rtl/seg_scan_pkg.sv
// ============================================================================
//  Module      : seg_scan_pkg
//  Description : Shared constants and types for the seven-segment scan decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_scan_pkg;

    // Active-low segment patterns, bit order GFEDCBA (bit 0 = segment A)
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low anode codes
    localparam logic [3:0] AN_R    = 4'b1110;
    localparam logic [3:0] AN_RC   = 4'b1101;
    localparam logic [3:0] AN_LC   = 4'b1011;
    localparam logic [3:0] AN_L    = 4'b0111;
    localparam logic [3:0] AN_NONE = 4'b1111;

    typedef enum logic [2:0] {
        SYNC = 3'd0,
        EXP0 = 3'd1,
        EXP1 = 3'd2,
        EXP2 = 3'd3,
        EXP3 = 3'd4
    } scanState_t;

    // Returns {oneHotLow, digitIndex[1:0]}
    function automatic logic [2:0] anodeDecode(input logic [3:0] an);
        logic [2:0] result;
        result = 3'b000;
        case (an)
            AN_R:    result = 3'b100;
            AN_RC:   result = 3'b101;
            AN_LC:   result = 3'b110;
            AN_L:    result = 3'b111;
            default: result = 3'b000;
        endcase
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
// ============================================================================
//  Module      : seg7_pattern_decode
//  Description : Combinational active-low GFEDCBA pattern to hex nibble decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_pattern_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] value
);

    always_comb begin
        legal = 1'b1;
        value = 4'h0;
        case (seg)
            SEG_0:   value = 4'h0;
            SEG_1:   value = 4'h1;
            SEG_2:   value = 4'h2;
            SEG_3:   value = 4'h3;
            SEG_4:   value = 4'h4;
            SEG_5:   value = 4'h5;
            SEG_6:   value = 4'h6;
            SEG_7:   value = 4'h7;
            SEG_8:   value = 4'h8;
            SEG_9:   value = 4'h9;
            SEG_A:   value = 4'hA;
            SEG_B:   value = 4'hB;
            SEG_C:   value = 4'hC;
            SEG_D:   value = 4'hD;
            SEG_E:   value = 4'hE;
            SEG_F:   value = 4'hF;
            default: legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg_scan_decoder.sv
// ============================================================================
//  Module      : seg_scan_decoder
//  Description : Receive side of a multiplexed 4-digit seven-segment bus;
//                decodes settled digits and publishes complete scan frames.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digit,
    output logic [3:0]  digit_valid,
    output logic [3:0]  digit_err,
    output logic [15:0] frame_value,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        scan_err
);

    localparam int                CNT_W          = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  c_settleMax    = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]  c_settleLast   = CNT_W'(SETTLE_CYCLES - 1);

    logic [3:0]        r_anQ;
    logic [6:0]        r_segQ;
    logic [CNT_W-1:0]  r_dwell;
    logic [15:0]       r_digit;
    logic [3:0]        r_digitValid;
    logic [3:0]        r_digitErr;
    logic [15:0]       r_frameValue;
    logic              r_frameValid;
    logic              r_frameErr;
    logic              r_scanErr;
    logic              r_acc;
    scanState_t        r_state;

    logic              w_same;
    logic              w_capture;
    logic [2:0]        w_anInfo;
    logic              w_oneHot;
    logic [1:0]        w_idx;
    logic              w_isDigit;
    logic              w_isIllegal;
    logic              w_legal;
    logic [3:0]        w_value;
    logic              w_capErr;
    logic [15:0]       w_digitNext;
    scanState_t        w_stateNext;
    logic              w_scanErrNext;
    logic              w_frameDone;
    logic              w_accNext;

    seg7_pattern_decode u_decode (
        .seg   (r_segQ),
        .legal (w_legal),
        .value (w_value)
    );

    // Capture fires exactly once per dwell: on the edge the count would reach SETTLE_CYCLES
    assign w_same      = ({an, seg} == {r_anQ, r_segQ});
    assign w_capture   = w_same && (r_dwell == c_settleLast);
    assign w_anInfo    = anodeDecode(r_anQ);
    assign w_oneHot    = w_anInfo[2];
    assign w_idx       = w_anInfo[1:0];
    assign w_isDigit   = w_capture && w_oneHot;
    assign w_isIllegal = w_capture && !w_oneHot && (r_anQ != AN_NONE);
    assign w_capErr    = !w_legal;

    always_comb begin
        w_digitNext = r_digit;
        if (w_isDigit && w_legal) begin
            w_digitNext[{w_idx, 2'b00} +: 4] = w_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anQ   <= 4'h0;
            r_segQ  <= 7'h00;
            r_dwell <= '0;
        end else begin
            r_anQ  <= an;
            r_segQ <= seg;
            if (!w_same) begin
                r_dwell <= '0;
            end else if (r_dwell != c_settleMax) begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit      <= 16'h0000;
            r_digitValid <= 4'h0;
            r_digitErr   <= 4'h0;
        end else begin
            r_digit <= w_digitNext;
            if (w_isDigit) begin
                r_digitValid[w_idx] <= w_legal;
                r_digitErr[w_idx]   <= !w_legal;
            end
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_scanErrNext = 1'b0;
        w_frameDone   = 1'b0;
        w_accNext     = r_acc;
        if (w_isIllegal) begin
            w_scanErrNext = 1'b1;
            w_stateNext   = SYNC;
        end else if (w_isDigit) begin
            case (r_state)
                SYNC: begin
                    if (w_idx == 2'd0) begin
                        w_stateNext = EXP1;
                        w_accNext   = w_capErr;
                    end
                end
                EXP0: begin
                    if (w_idx == 2'd0) begin
                        w_stateNext = EXP1;
                        w_accNext   = w_capErr;
                    end else begin
                        w_scanErrNext = 1'b1;
                        w_stateNext   = SYNC;
                    end
                end
                EXP1, EXP2, EXP3: begin
                    if ((r_state == EXP1 && w_idx == 2'd1) ||
                        (r_state == EXP2 && w_idx == 2'd2) ||
                        (r_state == EXP3 && w_idx == 2'd3)) begin
                        w_accNext = r_acc | w_capErr;
                        case (r_state)
                            EXP1:    w_stateNext = EXP2;
                            EXP2:    w_stateNext = EXP3;
                            default: begin
                                w_stateNext = EXP0;
                                w_frameDone = 1'b1;
                            end
                        endcase
                    end else if (w_idx == 2'd0) begin
                        // Early R: treat as the start of a new frame
                        w_scanErrNext = 1'b1;
                        w_stateNext   = EXP1;
                        w_accNext     = w_capErr;
                    end else begin
                        w_scanErrNext = 1'b1;
                        w_stateNext   = SYNC;
                    end
                end
                default: w_stateNext = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SYNC;
            r_acc        <= 1'b0;
            r_scanErr    <= 1'b0;
            r_frameValid <= 1'b0;
            r_frameValue <= 16'h0000;
            r_frameErr   <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_acc        <= w_accNext;
            r_scanErr    <= w_scanErrNext;
            r_frameValid <= w_frameDone;
            if (w_frameDone) begin
                r_frameValue <= w_digitNext;
                r_frameErr   <= w_accNext;
            end
        end
    end

    assign digit       = r_digit;
    assign digit_valid = r_digitValid;
    assign digit_err   = r_digitErr;
    assign frame_value = r_frameValue;
    assign frame_valid = r_frameValid;
    assign frame_err   = r_frameErr;
    assign scan_err    = r_scanErr;

endmodule

`default_nettype wire
